wb_commit_unit: RTL and testbench

Parametrised writeback/commit stage for the RISC-V pipeline; sits after the execute/memory transfer register and drives the register-file write port, PC select, the tohost CSR and an instret counter. Unlike the previous combinational writeback, it performs load-data alignment and sign/zero extension. It also waits on a variable-latency memory response, stalling upstream until the load data arrives, with a registered CSR and a retired-instruction counter.

---
 rtl/wb_commit_if.sv | 35 +++
 rtl/wb_commit_unit.sv | 146 ++++++++++++++
 tb/tb_wb_commit_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_commit_if.sv
// Port bundle for the writeback/commit stage: execute-side instruction,
// load response, and the commit-side outputs.
interface wb_commit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic [XLEN-1:0]  in_pc;
    logic [31:0]      in_inst;
    logic [XLEN-1:0]  in_alu;
    logic             in_jump;
    logic             mem_resp_valid;
    logic [XLEN-1:0]  mem_resp_data;
    logic             stall;
    logic             rwe;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             pc_sel;
    logic [XLEN-1:0]  csr_tohost;
    logic [CNT_W-1:0] instret;

    modport master (
        output in_valid, in_pc, in_inst, in_alu, in_jump,
        output mem_resp_valid, mem_resp_data,
        input  stall, rwe, wb_rd, wb_data, pc_sel,
        input  csr_tohost, instret
    );

    modport slave (
        input  in_valid, in_pc, in_inst, in_alu, in_jump,
        input  mem_resp_valid, mem_resp_data,
        output stall, rwe, wb_rd, wb_data, pc_sel,
        output csr_tohost, instret
    );
endinterface

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: load alignment, variable-latency load wait,
// tohost CSR and retired-instruction counter.
module wb_commit_unit #(
    parameter int          XLEN     = 32,
    parameter int          CNT_W    = 32,
    parameter logic [11:0] CSR_ADDR = 12'h51E
) (
    input logic        clk,
    input logic        reset,
    wb_commit_if.slave bus
);
    localparam int OFF_W = $clog2(XLEN / 8);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic {RUN, WAIT} state_t;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu;
    } pend_t;

    state_t           state, state_nx;
    pend_t            pend;
    logic [XLEN-1:0]  tohost;
    logic [CNT_W-1:0] count;

    logic [31:0]     inst;
    logic [XLEN-1:0] pc, alu;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [4:0]      rd;
    logic            is_load, miss, commit, stall;
    logic            writes, rwe, csr_hit;
    logic [XLEN-1:0] shifted, load_data, result;
    logic            unused_bits;

    // In WAIT the latched load drives the datapath; in_* is ignored.
    assign inst = (state == WAIT) ? pend.inst : bus.in_inst;
    assign pc   = (state == WAIT) ? pend.pc   : bus.in_pc;
    assign alu  = (state == WAIT) ? pend.alu  : bus.in_alu;

    assign opc         = inst[6:0];
    assign f3          = inst[14:12];
    assign rd          = inst[11:7];
    assign unused_bits = ^inst[19:15];
    assign is_load     = (opc == OP_LOAD);
    assign miss        = (state == RUN) & bus.in_valid & is_load
                       & ~bus.mem_resp_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            RUN:  if (miss) state_nx = WAIT;
            WAIT: if (bus.mem_resp_valid) state_nx = RUN;
        endcase
    end

    always_comb begin
        commit = 1'b0;
        stall  = 1'b0;
        unique case (state)
            RUN: begin
                commit = bus.in_valid & (~is_load | bus.mem_resp_valid);
                stall  = miss;
            end
            WAIT: begin
                commit = bus.mem_resp_valid;
                stall  = ~bus.mem_resp_valid;
            end
        endcase
    end

    assign shifted = bus.mem_resp_data >> {alu[OFF_W-1:0], 3'b000};

    always_comb begin
        unique case (f3)
            3'b000:  load_data = XLEN'($signed(shifted[7:0]));
            3'b001:  load_data = XLEN'($signed(shifted[15:0]));
            3'b010:  load_data = XLEN'($signed(shifted[31:0]));
            3'b100:  load_data = XLEN'(shifted[7:0]);
            3'b101:  load_data = XLEN'(shifted[15:0]);
            3'b110:  load_data = XLEN'(shifted[31:0]);
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        writes = 1'b0;
        result = alu;
        unique case (opc)
            OP_JAL, OP_JALR: begin
                writes = 1'b1;
                result = pc + XLEN'(4);
            end
            OP_LOAD: begin
                writes = 1'b1;
                result = load_data;
            end
            OP_LUI, OP_AUIPC, OP_OP, OP_IMM: writes = 1'b1;
            OP_OP32, OP_IMM32:               writes = (XLEN == 64);
            default:                         writes = 1'b0;
        endcase
    end

    assign rwe     = commit & writes & (rd != 5'd0);
    // CSRRW (001) and CSRRWI (101) are the only funct3 values with [1:0]=01.
    assign csr_hit = commit & (opc == OP_SYSTEM) & (f3[1:0] == 2'b01)
                   & (inst[31:20] == CSR_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend   <= '0;
            tohost <= '0;
            count  <= '0;
        end else begin
            if (miss)    pend   <= '{inst: bus.in_inst, pc: bus.in_pc,
                                     alu: bus.in_alu};
            if (csr_hit) tohost <= alu;
            if (commit)  count  <= count + CNT_W'(1);
        end
    end

    assign bus.stall      = stall;
    assign bus.rwe        = rwe;
    assign bus.wb_rd      = commit ? rd : 5'd0;
    assign bus.wb_data    = rwe ? result : '0;
    assign bus.pc_sel     = bus.in_valid & bus.in_jump & (state == RUN);
    assign bus.csr_tohost = tohost;
    assign bus.instret    = count;
endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit: RV32 main build, CNT_W=4 wrap build
// and RV64 load-extension build.
module tb_wb_commit_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    wb_commit_if #(.XLEN(32), .CNT_W(32)) b32 ();
    wb_commit_if #(.XLEN(32), .CNT_W(4))  b4 ();
    wb_commit_if #(.XLEN(64), .CNT_W(32)) b64 ();

    wb_commit_unit #(.XLEN(32), .CNT_W(32)) u32 (
        .clk(clk), .reset(reset), .bus(b32));
    wb_commit_unit #(.XLEN(32), .CNT_W(4)) u4 (
        .clk(clk), .reset(reset), .bus(b4));
    wb_commit_unit #(.XLEN(64), .CNT_W(32)) u64 (
        .clk(clk), .reset(reset), .bus(b64));

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drv32(input logic v, input logic [31:0] inst,
                         input logic [31:0] pc, input logic [31:0] alu,
                         input logic j, input logic rv,
                         input logic [31:0] rdata);
        b32.in_valid       = v;
        b32.in_inst        = inst;
        b32.in_pc          = pc;
        b32.in_alu         = alu;
        b32.in_jump        = j;
        b32.mem_resp_valid = rv;
        b32.mem_resp_data  = rdata;
    endtask

    task automatic drv64(input logic v, input logic [31:0] inst,
                         input logic [63:0] alu, input logic rv,
                         input logic [63:0] rdata);
        b64.in_valid       = v;
        b64.in_inst        = inst;
        b64.in_pc          = 64'h0;
        b64.in_alu         = alu;
        b64.in_jump        = 1'b0;
        b64.mem_resp_valid = rv;
        b64.mem_resp_data  = rdata;
    endtask

    initial begin
        reset = 1'b1;
        drv32(0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        drv64(0, 32'h0, 64'h0, 0, 64'h0);
        b4.in_valid       = 1'b0;
        b4.in_inst        = 32'h0;
        b4.in_pc          = 32'h0;
        b4.in_alu         = 32'h0;
        b4.in_jump        = 1'b0;
        b4.mem_resp_valid = 1'b0;
        b4.mem_resp_data  = 32'h0;
        mid();
        check("rst_stall", 64'(b32.stall), 64'd0);
        check("rst_rwe", 64'(b32.rwe), 64'd0);
        check("rst_pcsel", 64'(b32.pc_sel), 64'd0);
        check("rst_rd", 64'(b32.wb_rd), 64'd0);
        check("rst_csr", 64'(b32.csr_tohost), 64'd0);
        check("rst_instret", 64'(b32.instret), 64'd0);
        tick();
        reset = 1'b0;

        // ADDI x5 then JAL x1
        drv32(1, 32'h0000_0293, 32'hFC, 32'h1234, 0, 0, 32'h0);
        mid();
        check("addi_rwe", 64'(b32.rwe), 64'd1);
        check("addi_rd", 64'(b32.wb_rd), 64'd5);
        check("addi_data", 64'(b32.wb_data), 64'h1234);
        check("addi_pcsel", 64'(b32.pc_sel), 64'd0);
        tick();
        drv32(1, 32'h0000_00EF, 32'h100, 32'h0, 1, 0, 32'h0);
        mid();
        check("jal_rd", 64'(b32.wb_rd), 64'd1);
        check("jal_data", 64'(b32.wb_data), 64'h104);
        check("jal_pcsel", 64'(b32.pc_sel), 64'd1);
        tick();
        check("instret2", 64'(b32.instret), 64'd2);

        // same-cycle loads
        drv32(1, 32'h0000_0303, 32'h0, 32'h1003, 0, 1, 32'h80FF_0000);
        mid();
        check("lb_stall", 64'(b32.stall), 64'd0);
        check("lb_data", 64'(b32.wb_data), 64'hFFFF_FF80);
        tick();
        drv32(1, 32'h0000_4303, 32'h0, 32'h1003, 0, 1, 32'h80FF_0000);
        mid();
        check("lbu_data", 64'(b32.wb_data), 64'h80);
        tick();
        drv32(1, 32'h0000_5303, 32'h0, 32'h1002, 0, 1, 32'h80FF_0000);
        mid();
        check("lhu_data", 64'(b32.wb_data), 64'h80FF);
        tick();
        check("instret5", 64'(b32.instret), 64'd5);

        // LW x7 with response three cycles late; in_* churns meanwhile
        drv32(1, 32'h0000_2383, 32'h0, 32'h2000, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            mid();
            check("lw_stall", 64'(b32.stall), 64'd1);
            check("lw_wait_rwe", 64'(b32.rwe), 64'd0);
            tick();
            drv32(1, 32'h0000_0293, 32'h55, 32'hBAD, 0, 0, 32'h0);
        end
        drv32(1, 32'h0000_0293, 32'h55, 32'hBAD, 0, 1, 32'hDEAD_BEEF);
        mid();
        check("lw_resp_stall", 64'(b32.stall), 64'd0);
        check("lw_resp_rwe", 64'(b32.rwe), 64'd1);
        check("lw_resp_rd", 64'(b32.wb_rd), 64'd7);
        check("lw_resp_data", 64'(b32.wb_data), 64'hDEAD_BEEF);
        tick();
        check("instret6", 64'(b32.instret), 64'd6);
        drv32(0, 32'h0000_2383, 32'h0, 32'h2000, 0, 1, 32'h1);
        mid();
        check("late_resp_rwe", 64'(b32.rwe), 64'd0);
        check("late_resp_rd", 64'(b32.wb_rd), 64'd0);
        tick();
        check("instret6b", 64'(b32.instret), 64'd6);

        // tohost CSR
        drv32(1, 32'h51E0_1073, 32'h0, 32'h1, 0, 0, 32'h0);
        mid();
        check("csrrw_rwe", 64'(b32.rwe), 64'd0);
        tick();
        check("csr_hit", 64'(b32.csr_tohost), 64'd1);
        drv32(1, 32'h3000_1073, 32'h0, 32'h5, 0, 0, 32'h0);
        tick();
        check("csr_other", 64'(b32.csr_tohost), 64'd1);
        drv32(1, 32'h51E0_5073, 32'h0, 32'h77, 0, 0, 32'h0);
        tick();
        check("csrrwi_hit", 64'(b32.csr_tohost), 64'h77);
        check("instret9", 64'(b32.instret), 64'd9);

        // rd=x0, idle cycle, store, OP-IMM-32 on RV32
        drv32(1, 32'h0000_0033, 32'h0, 32'h99, 0, 0, 32'h0);
        mid();
        check("add_x0_rwe", 64'(b32.rwe), 64'd0);
        tick();
        check("instret10", 64'(b32.instret), 64'd10);
        drv32(0, 32'h0000_01B3, 32'h0, 32'h0, 1, 0, 32'h0);
        mid();
        check("idle_rwe", 64'(b32.rwe), 64'd0);
        check("idle_pcsel", 64'(b32.pc_sel), 64'd0);
        tick();
        check("instret_idle", 64'(b32.instret), 64'd10);
        drv32(1, 32'h0000_2023, 32'h0, 32'h0, 0, 0, 32'h0);
        mid();
        check("store_rwe", 64'(b32.rwe), 64'd0);
        tick();
        drv32(1, 32'h0000_029B, 32'h0, 32'h42, 0, 0, 32'h0);
        mid();
        check("addiw_rv32_rwe", 64'(b32.rwe), 64'd0);
        tick();
        check("instret12", 64'(b32.instret), 64'd12);

        // reset while waiting on a load
        drv32(1, 32'h0000_2383, 32'h0, 32'h2000, 0, 0, 32'h0);
        tick();
        drv32(1, 32'h0000_00EF, 32'h200, 32'h0, 1, 0, 32'h0);
        mid();
        check("wait_stall", 64'(b32.stall), 64'd1);
        check("wait_pcsel", 64'(b32.pc_sel), 64'd0);
        #1 reset = 1'b1;
        #1;
        check("rst_wait_stall", 64'(b32.stall), 64'd0);
        check("rst_wait_instret", 64'(b32.instret), 64'd0);
        check("rst_wait_csr", 64'(b32.csr_tohost), 64'd0);
        drv32(0, 32'h0000_2383, 32'h0, 32'h2000, 0, 0, 32'h0);
        tick();
        reset = 1'b0;
        drv32(0, 32'h0000_2383, 32'h0, 32'h2000, 0, 1, 32'h1234);
        mid();
        check("post_rst_rwe", 64'(b32.rwe), 64'd0);
        tick();
        check("post_rst_instret", 64'(b32.instret), 64'd0);
        drv32(0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0);

        // CNT_W=4 wrap
        b4.in_valid = 1'b1;
        b4.in_inst  = 32'h0000_01B3;
        repeat (15) tick();
        check("cnt4_max", 64'(b4.instret), 64'd15);
        tick();
        check("cnt4_wrap", 64'(b4.instret), 64'd0);
        b4.in_valid = 1'b0;

        // RV64 load extension
        drv64(1, 32'h0000_3303, 64'h0, 1, 64'h8000_0000_0000_0001);
        mid();
        check("ld_data", b64.wb_data, 64'h8000_0000_0000_0001);
        tick();
        drv64(1, 32'h0000_2303, 64'h4, 1, 64'h8765_4321_0000_0000);
        mid();
        check("lw64_data", b64.wb_data, 64'hFFFF_FFFF_8765_4321);
        tick();
        drv64(1, 32'h0000_6303, 64'h4, 1, 64'h8765_4321_0000_0000);
        mid();
        check("lwu64_data", b64.wb_data, 64'h0000_0000_8765_4321);
        tick();
        drv64(1, 32'h0000_0303, 64'h7, 1, 64'h8765_4321_0000_0000);
        mid();
        check("lb64_data", b64.wb_data, 64'hFFFF_FFFF_FFFF_FF87);
        tick();
        drv64(1, 32'h0000_029B, 64'h1_2345_6789, 0, 64'h0);
        mid();
        check("addiw64_rwe", 64'(b64.rwe), 64'd1);
        check("addiw64_data", b64.wb_data, 64'h1_2345_6789);
        tick();
        drv64(0, 32'h0, 64'h0, 0, 64'h0);
        check("instret64", 64'(b64.instret), 64'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
